// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings seen on Shifter_Mode_In.
package barrel_shifter_pkg;

  localparam int MODE_WIDTH = 3;

  localparam logic [MODE_WIDTH-1:0] LOGICAL_SHIFT_LEFT          = 3'd0;
  localparam logic [MODE_WIDTH-1:0] LOGICAL_SHIFT_RIGHT         = 3'd1;
  localparam logic [MODE_WIDTH-1:0] ARITHMETIC_SHIFT_LEFT       = 3'd2;
  localparam logic [MODE_WIDTH-1:0] ARITHMETIC_SHIFT_RIGHT      = 3'd3;
  localparam logic [MODE_WIDTH-1:0] ROTATE_LEFT                 = 3'd4;
  localparam logic [MODE_WIDTH-1:0] ROTATE_RIGHT                = 3'd5;
  localparam logic [MODE_WIDTH-1:0] ROTATE_LEFT_THROUGH_CARRY   = 3'd6;
  localparam logic [MODE_WIDTH-1:0] ROTATE_RIGHT_THROUGH_CARRY  = 3'd7;

endpackage

// File: rtl/barrel_shifter_stage.sv
// One pipeline stage of the barrel shifter: conditionally shifts by STAGE_SHIFT when the
// matching shift-amount bit is set, then registers the result together with its context.
module barrel_shifter_stage
  import barrel_shifter_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int STAGE_SHIFT = 1,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   valid_i,
  input  logic [MODE_WIDTH-1:0]  mode_i,
  input  logic [SHIFT_WIDTH-1:0] amount_i,
  input  logic                   sign_i,
  input  logic                   carry_i,
  input  logic                   overflow_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic                   valid_o,
  output logic [MODE_WIDTH-1:0]  mode_o,
  output logic [SHIFT_WIDTH-1:0] amount_o,
  output logic                   sign_o,
  output logic                   carry_o,
  output logic                   overflow_o,
  output logic [DATA_WIDTH-1:0]  data_o
);

  localparam int AMOUNT_BIT = $clog2(STAGE_SHIFT);

  logic                   valid_q;
  logic [MODE_WIDTH-1:0]  mode_q;
  logic [SHIFT_WIDTH-1:0] amount_q;
  logic                   sign_q;
  logic                   carry_d, carry_q;
  logic                   overflow_d, overflow_q;
  logic [DATA_WIDTH-1:0]  data_d, data_q;
  logic [DATA_WIDTH:0]    ext_word;
  logic [DATA_WIDTH:0]    ext_rot;
  logic                   asl_step_ovf;

  // Bits that pass through the MSB in an arithmetic left shift must all equal the original sign.
  always_comb begin
    ext_word     = {carry_i, data_i};
    ext_rot      = ext_word;
    data_d       = data_i;
    carry_d      = carry_i;
    overflow_d   = overflow_i;
    asl_step_ovf = |(data_i[DATA_WIDTH-1 -: STAGE_SHIFT+1] ^ {(STAGE_SHIFT+1){sign_i}});
    if (amount_i[AMOUNT_BIT]) begin
      case (mode_i)
        LOGICAL_SHIFT_LEFT: begin
          data_d  = data_i << STAGE_SHIFT;
          carry_d = data_i[DATA_WIDTH-STAGE_SHIFT];
        end
        ARITHMETIC_SHIFT_LEFT: begin
          data_d     = data_i << STAGE_SHIFT;
          carry_d    = data_i[DATA_WIDTH-STAGE_SHIFT];
          overflow_d = overflow_i | asl_step_ovf;
        end
        LOGICAL_SHIFT_RIGHT: begin
          data_d  = data_i >> STAGE_SHIFT;
          carry_d = data_i[STAGE_SHIFT-1];
        end
        ARITHMETIC_SHIFT_RIGHT: begin
          data_d  = $signed(data_i) >>> STAGE_SHIFT;
          carry_d = data_i[STAGE_SHIFT-1];
        end
        ROTATE_LEFT: begin
          data_d  = {data_i[DATA_WIDTH-STAGE_SHIFT-1:0], data_i[DATA_WIDTH-1 -: STAGE_SHIFT]};
          carry_d = data_i[DATA_WIDTH-STAGE_SHIFT];
        end
        ROTATE_RIGHT: begin
          data_d  = {data_i[STAGE_SHIFT-1:0], data_i[DATA_WIDTH-1:STAGE_SHIFT]};
          carry_d = data_i[STAGE_SHIFT-1];
        end
        ROTATE_LEFT_THROUGH_CARRY: begin
          ext_rot = {ext_word[DATA_WIDTH-STAGE_SHIFT:0], ext_word[DATA_WIDTH -: STAGE_SHIFT]};
          data_d  = ext_rot[DATA_WIDTH-1:0];
          carry_d = ext_rot[DATA_WIDTH];
        end
        ROTATE_RIGHT_THROUGH_CARRY: begin
          ext_rot = {ext_word[STAGE_SHIFT-1:0], ext_word[DATA_WIDTH:STAGE_SHIFT]};
          data_d  = ext_rot[DATA_WIDTH-1:0];
          carry_d = ext_rot[DATA_WIDTH];
        end
        default: begin
          data_d  = data_i;
          carry_d = carry_i;
        end
      endcase
    end else begin
      data_d     = data_i;
      carry_d    = carry_i;
      overflow_d = overflow_i;
    end
  end

  // Stage register; holds everything while the pipe is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      mode_q     <= {MODE_WIDTH{1'b0}};
      amount_q   <= {SHIFT_WIDTH{1'b0}};
      sign_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= {DATA_WIDTH{1'b0}};
    end else if (en_i) begin
      valid_q    <= valid_i;
      mode_q     <= mode_i;
      amount_q   <= amount_i;
      sign_q     <= sign_i;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
    end
  end

  assign valid_o    = valid_q;
  assign mode_o     = mode_q;
  assign amount_o   = amount_q;
  assign sign_o     = sign_q;
  assign carry_o    = carry_q;
  assign overflow_o = overflow_q;
  assign data_o     = data_q;

endmodule

// File: rtl/barrel_shifter_pipelined.sv
// Pipelined barrel shifter/rotator: one registered stage per shift-amount bit, whole-pipe
// stall on output backpressure, outputs taken straight from the last stage registers.
module barrel_shifter_pipelined
  import barrel_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                           Clock_In,
  input  logic                           Reset_In,
  input  logic                           In_Valid_In,
  output logic                           In_Ready_Out,
  input  logic [2:0]                     Shifter_Mode_In,
  input  logic [$clog2(DATA_WIDTH)-1:0]  Shift_Amount_In,
  input  logic                           Carry_In,
  input  logic [DATA_WIDTH-1:0]          Data_In,
  output logic                           Out_Valid_Out,
  input  logic                           Out_Ready_In,
  output logic [DATA_WIDTH-1:0]          Shifted_Data_Out,
  output logic                           Carry_Out,
  output logic                           Overflow_Out
);

  localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH);

  logic [SHIFT_WIDTH:0]    stage_valid;
  logic [SHIFT_WIDTH:0]    stage_sign;
  logic [SHIFT_WIDTH:0]    stage_carry;
  logic [SHIFT_WIDTH:0]    stage_overflow;
  logic [MODE_WIDTH-1:0]   stage_mode   [SHIFT_WIDTH+1];
  logic [SHIFT_WIDTH-1:0]  stage_amount [SHIFT_WIDTH+1];
  logic [DATA_WIDTH-1:0]   stage_data   [SHIFT_WIDTH+1];
  logic                    advance;
  logic                    unused_tail;

  // Slot 0 is the raw request; the sign is captured once for ASR fill and ASL overflow.
  assign stage_valid[0]    = In_Valid_In;
  assign stage_mode[0]     = Shifter_Mode_In;
  assign stage_amount[0]   = Shift_Amount_In;
  assign stage_sign[0]     = Data_In[DATA_WIDTH-1];
  assign stage_carry[0]    = Carry_In;
  assign stage_overflow[0] = 1'b0;
  assign stage_data[0]     = Data_In;

  assign advance      = ~stage_valid[SHIFT_WIDTH] | Out_Ready_In;
  assign In_Ready_Out = advance;

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    barrel_shifter_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .STAGE_SHIFT (32'd1 << k),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_stage (
      .clk_i      (Clock_In),
      .rst_i      (Reset_In),
      .en_i       (advance),
      .valid_i    (stage_valid[k]),
      .mode_i     (stage_mode[k]),
      .amount_i   (stage_amount[k]),
      .sign_i     (stage_sign[k]),
      .carry_i    (stage_carry[k]),
      .overflow_i (stage_overflow[k]),
      .data_i     (stage_data[k]),
      .valid_o    (stage_valid[k+1]),
      .mode_o     (stage_mode[k+1]),
      .amount_o   (stage_amount[k+1]),
      .sign_o     (stage_sign[k+1]),
      .carry_o    (stage_carry[k+1]),
      .overflow_o (stage_overflow[k+1]),
      .data_o     (stage_data[k+1])
    );
  end

  assign Out_Valid_Out    = stage_valid[SHIFT_WIDTH];
  assign Shifted_Data_Out = stage_data[SHIFT_WIDTH];
  assign Carry_Out        = stage_carry[SHIFT_WIDTH];
  assign Overflow_Out     = stage_overflow[SHIFT_WIDTH];

  assign unused_tail = ^{stage_mode[SHIFT_WIDTH], stage_amount[SHIFT_WIDTH], stage_sign[SHIFT_WIDTH]};

endmodule

// File: tb/tb_barrel_shifter_pipelined.sv
// Self-checking bench: directed examples, stall/reset scenarios and randomized traffic
// compared against an arithmetic reference model through a scoreboard queue.
module tb_barrel_shifter_pipelined;

  localparam int DW = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    mode;
  logic [SW-1:0] amt;
  logic          cin;
  logic [DW-1:0] din;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic          cout;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  int discarded = 0;
  logic rand_done = 1'b0;
  logic [DW+1:0] exp_q[$];

  always #5 clk = ~clk;

  barrel_shifter_pipelined #(.DATA_WIDTH(DW)) dut (
    .Clock_In         (clk),
    .Reset_In         (rst),
    .In_Valid_In      (in_valid),
    .In_Ready_Out     (in_ready),
    .Shifter_Mode_In  (mode),
    .Shift_Amount_In  (amt),
    .Carry_In         (cin),
    .Data_In          (din),
    .Out_Valid_Out    (out_valid),
    .Out_Ready_In     (out_ready),
    .Shifted_Data_Out (dout),
    .Carry_Out        (cout),
    .Overflow_Out     (ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {overflow, carry, data} computed on whole words.
  function automatic logic [DW+1:0] model(input logic [2:0] m, input int n,
                                          input logic [DW-1:0] d, input logic c);
    logic [DW-1:0]   r;
    logic            co;
    logic            ov;
    logic [DW:0]     w;
    logic [DW:0]     wr;
    logic [2*DW-1:0] wide;
    int              top;
    r  = d;
    co = c;
    ov = 1'b0;
    w  = {c, d};
    if (n != 0) begin
      case (m)
        3'd0, 3'd2: begin
          wide = {{DW{1'b0}}, d} << n;
          r    = wide[DW-1:0];
          co   = wide[DW];
          if (m == 3'd2) begin
            top = int'(d >> (DW - 1 - n));
            ov  = !(top == 0 || top == ((1 << (n + 1)) - 1));
          end
        end
        3'd1: begin r = d >> n; co = d[n-1]; end
        3'd3: begin r = $signed(d) >>> n; co = d[n-1]; end
        3'd4: begin r = (d << n) | (d >> (DW - n)); co = r[0]; end
        3'd5: begin r = (d >> n) | (d << (DW - n)); co = r[DW-1]; end
        3'd6: begin wr = (w << n) | (w >> (DW + 1 - n)); r = wr[DW-1:0]; co = wr[DW]; end
        3'd7: begin wr = (w >> n) | (w << (DW + 1 - n)); r = wr[DW-1:0]; co = wr[DW]; end
        default: begin r = d; co = c; end
      endcase
    end
    return {ov, co, r};
  endfunction

  // Scoreboard: check the output transfer first, then record the input transfer.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", 32'd1, 32'd0);
        end else begin
          check_eq("sb_data", dout, exp_q[0][DW-1:0]);
          check_eq("sb_carry", cout, exp_q[0][DW]);
          check_eq("sb_ovf", ovf, exp_q[0][DW+1]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(model(mode, int'(amt), din, cin));
        pushed++;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [SW-1:0] a, input logic [DW-1:0] d, input logic c);
    logic acc;
    int   tries;
    mode = m; amt = a; din = d; cin = c; in_valid = 1'b1;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      cycle();
      tries++;
    end
    if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_random();
    send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic run_directed(input string tag, input logic [2:0] m, input logic [SW-1:0] a,
                              input logic [DW-1:0] d, input logic c,
                              input logic [DW-1:0] ed, input logic ec, input logic eo);
    int lat;
    out_ready = 1'b1;
    send(m, a, d, c);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      cycle();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 32'd3);
    check_eq({tag, "_data"}, dout, ed);
    check_eq({tag, "_carry"}, cout, ec);
    check_eq({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      cycle();
      t++;
    end
    check_eq(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 3'd0; amt = 3'd0; din = 8'h00; cin = 1'b0; out_ready = 1'b0;
    repeat (3) cycle();
    check_eq("rst_valid", out_valid, 32'd0);
    check_eq("rst_data", dout, 32'd0);
    check_eq("rst_carry", cout, 32'd0);
    check_eq("rst_ovf", ovf, 32'd0);
    rst = 1'b0;
    cycle();
    check_eq("rst_in_ready", in_ready, 32'd1);

    run_directed("lsl_96_4", 3'd0, 3'd4, 8'h96, 1'b0, 8'h60, 1'b1, 1'b0);
    run_directed("asr_96_2", 3'd3, 3'd2, 8'h96, 1'b0, 8'hE5, 1'b1, 1'b0);
    run_directed("asl_40_1", 3'd2, 3'd1, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
    run_directed("asl_10_3", 3'd2, 3'd3, 8'h10, 1'b0, 8'h80, 1'b0, 1'b1);
    run_directed("asl_f0_3", 3'd2, 3'd3, 8'hF0, 1'b0, 8'h80, 1'b1, 1'b0);
    run_directed("rrc_01_1", 3'd7, 3'd1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_directed("rlc_80_2", 3'd6, 3'd2, 8'h80, 1'b1, 8'h03, 1'b0, 1'b0);
    run_directed("lsr_80_7", 3'd1, 3'd7, 8'h80, 1'b0, 8'h01, 1'b0, 1'b0);
    for (int m = 0; m < 8; m++) begin
      run_directed($sformatf("amt0_m%0d", m), 3'(m), 3'd0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0);
    end
    wait_drain("directed_drain");

    // Six back-to-back ops against five cycles of backpressure.
    fork
      begin
        for (int i = 0; i < 6; i++) send_random();
      end
      begin
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
          cycle();
          if (i >= 3) check_eq("stall_in_ready", in_ready, 32'd0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("stall_drain");

    // Three ops in flight, then a one-cycle reset.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_random();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    discarded += exp_q.size();
    exp_q.delete();
    check_eq("midrst_valid", out_valid, 32'd0);
    check_eq("midrst_data", dout, 32'd0);
    check_eq("midrst_carry", cout, 32'd0);
    check_eq("midrst_ovf", ovf, 32'd0);
    check_eq("midrst_in_ready", in_ready, 32'd1);
    out_ready = 1'b1;
    repeat (8) cycle();

    // Random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) cycle();
          send_random();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          cycle();
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("random_drain");
    check_eq("no_loss_no_dup", popped, pushed - discarded);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
